// File: rtl/text_vram_2k_pkg.sv
// Shared constants for the 2048x8 text display RAM: command op-codes,
// sequencer state encoding and array geometry.
package text_vram_pkg;

  localparam int unsigned DEPTH         = 2048;
  localparam int unsigned ROW_STRIDE    = 64;
  localparam int unsigned LAST_ROW_BASE = DEPTH - ROW_STRIDE;

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_CLEAR  = 2'd2;
  localparam logic [1:0] OP_SCROLL = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCROLL_RD,
    SCROLL_WR,
    SCROLL_FILL
  } state_e;

endpackage

// File: rtl/text_vram_2k_if.sv
// Command/response bundle between CPU or terminal logic and the text VRAM.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// cmd_op/cmd_addr/cmd_wdata must be stable while cmd_valid is high, and the
// master may raise or drop cmd_valid freely.
// rsp_valid and op_done are single-cycle pulses with no back-pressure.
interface text_vram_2k_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [10:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        op_done;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data, op_done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data, op_done
  );
endinterface

// File: rtl/dp_ram_2k8.sv
// 2048x8 true dual-port RAM: port A read-only, port B read/write, both
// read-first with registered outputs (output registers clear on reset).
module dp_ram_2k8
  import text_vram_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] a_addr,
  output logic [7:0]  a_rdata,
  input  logic [10:0] b_addr,
  input  logic        b_we,
  input  logic [7:0]  b_wdata,
  output logic [7:0]  b_rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_wdata;
  end

  // Reads sample the array before this edge's write lands (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_rdata <= mem[a_addr];
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/text_vram_2k.sv
// Text display RAM with video read port, command port and clear/scroll
// sequencers. Optional blinking cursor overlay: TEXT_VRAM_CURSOR_EN.
module text_vram_2k
  import text_vram_pkg::*;
#(
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter int         COLS_LOG2 = 6,
  parameter int         ROWS_LOG2 = 5
`ifdef TEXT_VRAM_CURSOR_EN
  ,
  parameter logic [7:0] CURSOR_CHAR      = 8'hDB,
  parameter int         CURSOR_BLINK_CYC = 12500000
`endif
) (
  input  logic          clk_pixel,
  input  logic          n_reset,
  input  logic [10:0]   disp_addr,
  output logic [7:0]    disp_data,
  text_vram_2k_if.slave cmd_if,
`ifdef TEXT_VRAM_CURSOR_EN
  input  logic [10:0]   cursor_addr,
`endif
  output state_e        state_dbg
);

  localparam logic [10:0] STRIDE    = 11'(1 << COLS_LOG2);
  localparam logic [10:0] LAST_BASE = 11'(((1 << ROWS_LOG2) - 1) << COLS_LOG2);

  state_e      state_q, state_d;
  logic [10:0] ptr_q, ptr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_hold_q, rsp_hold_d;
  logic        op_done_q, op_done_d;

  logic [10:0] b_addr;
  logic        b_we;
  logic [7:0]  b_wdata;
  logic [7:0]  b_rdata;
  logic [7:0]  ram_disp;
  logic        accept;

  dp_ram_2k8 u_ram (
    .clk     (clk_pixel),
    .rst_n   (n_reset),
    .a_addr  (disp_addr),
    .a_rdata (ram_disp),
    .b_addr  (b_addr),
    .b_we    (b_we),
    .b_wdata (b_wdata),
    .b_rdata (b_rdata)
  );

  assign cmd_if.cmd_ready = (state_q == IDLE);
  assign accept           = cmd_if.cmd_valid && cmd_if.cmd_ready;
  assign cmd_if.rsp_valid = rsp_valid_q;
  // Port B output is only meaningful in the pulse cycle; hold it afterwards.
  assign cmd_if.rsp_data  = rsp_valid_q ? b_rdata : rsp_hold_q;
  assign cmd_if.op_done   = op_done_q;
  assign state_dbg        = state_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_valid_d = 1'b0;
    op_done_d   = 1'b0;
    rsp_hold_d  = rsp_valid_q ? b_rdata : rsp_hold_q;
    b_addr      = cmd_if.cmd_addr;
    b_we        = 1'b0;
    b_wdata     = cmd_if.cmd_wdata;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_if.cmd_op)
            OP_WRITE:  b_we = 1'b1;
            OP_READ:   rsp_valid_d = 1'b1;
            OP_CLEAR:  begin state_d = CLEAR;     ptr_d = '0; end
            default:   begin state_d = SCROLL_RD; ptr_d = '0; end
          endcase
        end
      end
      CLEAR, SCROLL_FILL: begin
        b_addr  = ptr_q;
        b_we    = 1'b1;
        b_wdata = FILL_CHAR;
        ptr_d   = ptr_q + 11'd1;
        if (ptr_q == '1) begin
          state_d   = IDLE;
          op_done_d = 1'b1;
        end
      end
      SCROLL_RD: begin
        b_addr  = ptr_q + STRIDE;
        state_d = SCROLL_WR;
      end
      SCROLL_WR: begin
        // b_rdata carries the byte fetched one row below in SCROLL_RD.
        b_addr  = ptr_q;
        b_we    = 1'b1;
        b_wdata = b_rdata;
        ptr_d   = ptr_q + 11'd1;
        state_d = (ptr_q == LAST_BASE - 11'd1) ? SCROLL_FILL : SCROLL_RD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hold_q  <= '0;
      op_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hold_q  <= rsp_hold_d;
      op_done_q   <= op_done_d;
    end
  end

`ifdef TEXT_VRAM_CURSOR_EN
  localparam int CW = $clog2(CURSOR_BLINK_CYC + 1);

  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [10:0]   disp_addr_q, disp_addr_d;

  always_comb begin
    disp_addr_d   = disp_addr;
    blink_cnt_d   = blink_cnt_q + CW'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == CW'(CURSOR_BLINK_CYC - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk_pixel or negedge n_reset) begin
    if (!n_reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      disp_addr_q   <= '0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      disp_addr_q   <= disp_addr_d;
    end
  end

  // disp_addr_q tracks the address behind ram_disp, so latency is unchanged.
  assign disp_data = (blink_phase_q && (disp_addr_q == cursor_addr)) ? CURSOR_CHAR : ram_disp;
`else
  assign disp_data = ram_disp;
`endif

endmodule

// File: tb/tb_text_vram_2k.sv
// Directed bench for text_vram_2k: command round-trips, clear, scroll,
// read-first collision, mid-sequence reset and (TEXT_VRAM_CURSOR_EN) cursor blink.
module tb_text_vram_2k;
  import text_vram_pkg::*;

  logic        clk_pixel = 1'b0;
  logic        n_reset;
  logic [10:0] disp_addr;
  logic [7:0]  disp_data;
  state_e      state_dbg;

  text_vram_2k_if cmd_if ();

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  logic [7:0]  exp_q[$];

`ifdef TEXT_VRAM_CURSOR_EN
  logic [10:0] cursor_addr;
  text_vram_2k #(.CURSOR_BLINK_CYC(4)) dut (
    .clk_pixel   (clk_pixel),
    .n_reset     (n_reset),
    .disp_addr   (disp_addr),
    .disp_data   (disp_data),
    .cmd_if      (cmd_if.slave),
    .cursor_addr (cursor_addr),
    .state_dbg   (state_dbg)
  );
`else
  text_vram_2k dut (
    .clk_pixel (clk_pixel),
    .n_reset   (n_reset),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .cmd_if    (cmd_if.slave),
    .state_dbg (state_dbg)
  );
`endif

  // ---------------- clock / reset ----------------
  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk_pixel) begin
    if (n_reset === 1'b1) begin
      if (cmd_if.op_done === 1'b1) done_cnt++;
      if (cmd_if.rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 32'(cmd_if.rsp_valid), 32'd0);
        else check("rsp_data", 32'(cmd_if.rsp_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic cmd(input logic [1:0] op, input logic [10:0] a, input logic [7:0] d);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_addr  = a;
    cmd_if.cmd_wdata = d;
    @(negedge clk_pixel);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wr(input logic [10:0] a, input logic [7:0] d);
    cmd(OP_WRITE, a, d);
  endtask

  task automatic rd(input logic [10:0] a, input logic [7:0] exp);
    exp_q.push_back(exp);
    cmd(OP_READ, a, 8'h00);
    check("rd_valid", 32'(cmd_if.rsp_valid), 32'd1);
  endtask

  // Start CLEAR/SCROLL, poke a write at 0x3FF while busy, measure busy length.
  task automatic run_seq(input logic [1:0] op, input int exp_busy, input string tag);
    int cnt;
    int d0;
    d0  = done_cnt;
    cnt = 0;
    cmd(op, 11'h000, 8'h00);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_WRITE;
    cmd_if.cmd_addr  = 11'h3FF;
    cmd_if.cmd_wdata = 8'h99;
    while (cmd_if.cmd_ready !== 1'b1 && cnt < 5000) begin
      cnt++;
      @(negedge clk_pixel);
    end
    cmd_if.cmd_valid = 1'b0;
    check({tag, "_busy"}, 32'(cnt), 32'(exp_busy));
    @(negedge clk_pixel);
    check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_done_pulse"}, 32'(cmd_if.op_done), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    n_reset          = 1'b0;
    disp_addr        = 11'h000;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_WRITE;
    cmd_if.cmd_addr  = 11'h000;
    cmd_if.cmd_wdata = 8'h00;
`ifdef TEXT_VRAM_CURSOR_EN
    cursor_addr = 11'h010;
`endif
    repeat (3) @(negedge clk_pixel);
    check("rst_disp_data", 32'(disp_data), 32'h00);
    check("rst_rsp_data", 32'(cmd_if.rsp_data), 32'h00);
    check("rst_rsp_valid", 32'(cmd_if.rsp_valid), 32'd0);
    check("rst_op_done", 32'(cmd_if.op_done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    n_reset = 1'b1;
    @(negedge clk_pixel);
    check("rst_cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);

    // Single write/read round-trip and video port readback.
    wr(11'h045, 8'h41);
    rd(11'h045, 8'h41);
    disp_addr = 11'h045;
    @(negedge clk_pixel);
    check("disp_045", 32'(disp_data), 32'h41);

    // Back-to-back write then read of the same address, pipelined reads.
    wr(11'h046, 8'h5A);
    rd(11'h046, 8'h5A);
    rd(11'h045, 8'h41);
    wr(11'h047, 8'h01);
    @(negedge clk_pixel);
    check("rsp_hold", 32'(cmd_if.rsp_data), 32'h41);

    // Port A read during port B write to the same address returns the old byte.
    wr(11'h100, 8'h11);
    disp_addr = 11'h100;
    wr(11'h100, 8'h55);
    check("collide_old", 32'(disp_data), 32'h11);
    @(negedge clk_pixel);
    check("collide_new", 32'(disp_data), 32'h55);

    // CLEAR; the write offered while busy must be ignored.
    run_seq(OP_CLEAR, 2048, "clear");
    rd(11'h000, 8'h20);
    rd(11'h3FF, 8'h20);
    rd(11'h7FF, 8'h20);
    @(negedge clk_pixel);

    // Fill RAM[i]=i[7:0], then SCROLL.
    for (int i = 0; i < 2048; i++) wr(11'(i), 8'(i));
    run_seq(OP_SCROLL, 4032, "scroll");
    rd(11'd0,    8'h40);
    rd(11'd1,    8'h41);
    rd(11'd1000, 8'h28);
    rd(11'd1023, 8'h3F);
    rd(11'd1983, 8'hFF);
    rd(11'(LAST_ROW_BASE), 8'h20);
    rd(11'd2047, 8'h20);
    disp_addr = 11'd0;
    @(negedge clk_pixel);
    check("disp_scrolled", 32'(disp_data), 32'h40);

    // Reset in the middle of a SCROLL.
    disp_addr = 11'd1;
    cmd(OP_SCROLL, 11'h000, 8'h00);
    repeat (999) @(negedge clk_pixel);
    check("mid_state_busy", 32'(cmd_if.cmd_ready), 32'd0);
    d0 = done_cnt;
    n_reset = 1'b0;
    #1;
    check("mid_rst_disp", 32'(disp_data), 32'h00);
    check("mid_rst_rsp_data", 32'(cmd_if.rsp_data), 32'h00);
    check("mid_rst_op_done", 32'(cmd_if.op_done), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    repeat (3) @(negedge clk_pixel);
    n_reset = 1'b1;
    @(negedge clk_pixel);
    check("mid_cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);
    repeat (4100) @(negedge clk_pixel);
    check("mid_no_done", 32'(done_cnt - d0), 32'd0);
    wr(11'h7A0, 8'h77);
    rd(11'h7A0, 8'h77);
    @(negedge clk_pixel);

`ifdef TEXT_VRAM_CURSOR_EN
    begin
      logic [7:0] s [20];
      int k;
      wr(11'h010, 8'h41);
      wr(11'h011, 8'h42);
      disp_addr = 11'h010;
      @(negedge clk_pixel);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk_pixel);
        s[i] = disp_data;
      end
      k = 1;
      while (k < 20 && s[k] == s[k-1]) k++;
      check("cur_edge", 32'(k <= 4), 32'd1);
      check("cur_pair", 32'(s[k % 20] ^ s[(k - 1) % 20]), 32'(8'h41 ^ 8'hDB));
      for (int j = k; j < k + 12 && j < 20; j++)
        check("cur_blink", 32'(s[j]), 32'((((j - k) / 4) % 2 == 0) ? s[k] : s[k-1]));
      disp_addr = 11'h011;
      @(negedge clk_pixel);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk_pixel);
        check("cur_other", 32'(disp_data), 32'h42);
      end
    end
`endif

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
